// File: rtl/ila_mon_pkg.sv
// Shared types for the instruction-window monitor: sequencing states and
// the width of the completed-instruction counter.
package ila_mon_pkg;

    localparam int INSTR_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        ENDED = 3'd3,
        DONE  = 3'd4
    } ila_state_e;

endpackage

// File: rtl/ila_mon_map_checker.sv
// Refinement-map comparator: masked mismatch reduction, sticky fail flag and,
// with ILA_MON_FAIL_LOG_EN defined, a first-mismatch capture log.
module ila_mon_map_checker
    import ila_mon_pkg::*;
#(
    parameter int NUM_MAP = 13,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               compare_i,
    input  logic [NUM_MAP-1:0] map_eq_i,
    input  logic [NUM_MAP-1:0] map_en_i,
`ifdef ILA_MON_FAIL_LOG_EN
    input  logic [CNT_W-1:0]   cycle_cnt_i,
    output logic [NUM_MAP-1:0] fail_vec_o,
    output logic [CNT_W-1:0]   fail_cyc_o,
`endif
    output logic               fail_o
);

    logic [NUM_MAP-1:0] diff_s;
    logic               mismatch_s;
    logic               fail_d;
    logic               fail_q;

    // Mismatch only counts while the compare window is open.
    always_comb begin
        diff_s     = map_en_i & ~map_eq_i;
        mismatch_s = compare_i & (|diff_s);
        fail_d     = fail_q | mismatch_s;
    end

    // Sticky fail flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign fail_o = fail_q;

`ifdef ILA_MON_FAIL_LOG_EN
    logic [NUM_MAP-1:0] fail_vec_d;
    logic [NUM_MAP-1:0] fail_vec_q;
    logic [CNT_W-1:0]   fail_cyc_d;
    logic [CNT_W-1:0]   fail_cyc_q;

    // Capture only the first mismatch after reset; later ones leave the log frozen.
    always_comb begin
        fail_vec_d = fail_vec_q;
        fail_cyc_d = fail_cyc_q;
        if (mismatch_s && !fail_q) begin
            fail_vec_d = diff_s;
            fail_cyc_d = cycle_cnt_i;
        end else begin
            fail_vec_d = fail_vec_q;
            fail_cyc_d = fail_cyc_q;
        end
    end

    // First-mismatch log registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_vec_q <= {NUM_MAP{1'b0}};
            fail_cyc_q <= {CNT_W{1'b0}};
        end else begin
            fail_vec_q <= fail_vec_d;
            fail_cyc_q <= fail_cyc_d;
        end
    end

    assign fail_vec_o = fail_vec_q;
    assign fail_cyc_o = fail_cyc_q;
`endif

endmodule

// File: rtl/ila_instr_window_monitor.sv
// Instruction-window monitor: issue/start/run/end sequencing with a saturating
// cycle counter and map check. ILA_MON_FAIL_LOG_EN adds the first-fail log ports.
module ila_instr_window_monitor
    import ila_mon_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int MAX_CYCLES = 6,
    parameter int END_CYCLE  = 1,
    parameter int END2_CYCLE = 3,
    parameter int NUM_MAP    = 13,
    parameter int MULTI_SHOT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_i,
    input  logic [NUM_MAP-1:0]     map_eq_i,
    input  logic [NUM_MAP-1:0]     map_en_i,
    output logic                   start_o,
    output logic                   started_o,
    output logic [CNT_W-1:0]       cycle_cnt_o,
    output logic                   iend_o,
    output logic                   ended_o,
    output logic                   end2_o,
    output logic                   ended2_o,
    output logic                   compare_o,
    output logic                   fail_o,
`ifdef ILA_MON_FAIL_LOG_EN
    output logic [NUM_MAP-1:0]     fail_vec_o,
    output logic [CNT_W-1:0]       fail_cyc_o,
`endif
    output logic [INSTR_CNT_W-1:0] instr_cnt_o
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(END_CYCLE);
    localparam logic [CNT_W-1:0] END2_CNT = CNT_W'(END2_CYCLE);
    localparam logic             MULTI_EN = (MULTI_SHOT != 0);

    if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
        $error("CNT_W must be in 1..30");
    end
    if (MAX_CYCLES >= (1 << CNT_W)) begin : g_bad_max
        $error("MAX_CYCLES must be < 2**CNT_W");
    end
    if (END_CYCLE < 1) begin : g_bad_end
        $error("END_CYCLE must be >= 1");
    end
    if (END_CYCLE >= END2_CYCLE || END2_CYCLE > MAX_CYCLES) begin : g_bad_end2
        $error("Need END_CYCLE < END2_CYCLE <= MAX_CYCLES");
    end
    if (NUM_MAP < 1) begin : g_bad_num_map
        $error("NUM_MAP must be >= 1");
    end
    if (MULTI_SHOT != 0 && MULTI_SHOT != 1) begin : g_bad_multi
        $error("MULTI_SHOT must be 0 or 1");
    end

    ila_state_e             state_d;
    ila_state_e             state_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   start_d;
    logic                   start_q;
    logic                   started_d;
    logic                   started_q;
    logic                   ended_d;
    logic                   ended_q;
    logic                   ended2_d;
    logic                   ended2_q;
    logic [INSTR_CNT_W-1:0] instr_cnt_d;
    logic [INSTR_CNT_W-1:0] instr_cnt_q;
    logic                   iend_s;
    logic                   end2_s;
    logic                   compare_s;

    // End-point decodes and the compare window.
    always_comb begin
        iend_s    = (state_q == RUN) && (cnt_q == END_CNT);
        end2_s    = (state_q == ENDED) && (cnt_q == END2_CNT);
        compare_s = iend_s | ended_q;
    end

    // Sequencing next state; issue_i is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_i) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (iend_s) begin
                    state_d = ENDED;
                end else begin
                    state_d = RUN;
                end
            end
            ENDED: begin
                if (end2_s) begin
                    state_d = MULTI_EN ? IDLE : DONE;
                end else begin
                    state_d = ENDED;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Counter, status flags and instruction count derived from the next state.
    always_comb begin
        cnt_d       = cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (end2_s && MULTI_EN) begin
            cnt_d       = {CNT_W{1'b0}};
            instr_cnt_d = instr_cnt_q + INSTR_CNT_W'(1);
        end else if ((start_q || started_q) && (cnt_q != MAX_CNT)) begin
            cnt_d       = cnt_q + CNT_W'(1);
            instr_cnt_d = instr_cnt_q;
        end else begin
            cnt_d       = cnt_q;
            instr_cnt_d = instr_cnt_q;
        end
        start_d   = (state_d == START);
        started_d = (state_d == RUN) || (state_d == ENDED) || (state_d == DONE);
        ended_d   = (state_d == ENDED) || (state_d == DONE);
        ended2_d  = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            start_q     <= 1'b0;
            started_q   <= 1'b0;
            ended_q     <= 1'b0;
            ended2_q    <= 1'b0;
            instr_cnt_q <= {INSTR_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            started_q   <= started_d;
            ended_q     <= ended_d;
            ended2_q    <= ended2_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    ila_mon_map_checker #(
        .NUM_MAP (NUM_MAP),
        .CNT_W   (CNT_W)
    ) u_map_checker (
        .clk         (clk),
        .rst         (rst),
        .compare_i   (compare_s),
        .map_eq_i    (map_eq_i),
        .map_en_i    (map_en_i),
`ifdef ILA_MON_FAIL_LOG_EN
        .cycle_cnt_i (cnt_q),
        .fail_vec_o  (fail_vec_o),
        .fail_cyc_o  (fail_cyc_o),
`endif
        .fail_o      (fail_o)
    );

    assign start_o     = start_q;
    assign started_o   = started_q;
    assign cycle_cnt_o = cnt_q;
    assign iend_o      = iend_s;
    assign ended_o     = ended_q;
    assign end2_o      = end2_s;
    assign ended2_o    = ended2_q;
    assign compare_o   = compare_s;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_ila_instr_window_monitor.sv
// Bench for ila_instr_window_monitor: a single-shot and a multi-shot instance
// with default parameters, table-driven trace plus hand-written corner cases.
module tb_ila_instr_window_monitor;

    localparam logic [12:0] ALL  = 13'h1FFF;
    localparam logic [12:0] NO5  = 13'h1FDF;
    localparam logic [12:0] NO3  = 13'h1FF7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_issue = 1'b0;
    logic [12:0] ss_eq = 13'h1FFF;
    logic [12:0] ss_en = 13'h1FFF;
    logic        ms_issue = 1'b0;
    logic [12:0] ms_eq = 13'h1FFF;
    logic [12:0] ms_en = 13'h1FFF;

    logic        ss_start, ss_started, ss_iend, ss_ended, ss_end2, ss_ended2, ss_compare, ss_fail;
    logic [3:0]  ss_cnt;
    logic [7:0]  ss_instr;
    logic        ms_start, ms_started, ms_iend, ms_ended, ms_end2, ms_ended2, ms_compare, ms_fail;
    logic [3:0]  ms_cnt;
    logic [7:0]  ms_instr;
`ifdef ILA_MON_FAIL_LOG_EN
    logic [12:0] ss_fvec, ms_fvec;
    logic [3:0]  ss_fcyc, ms_fcyc;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ila_instr_window_monitor #(.MULTI_SHOT(0)) dut_ss (
        .clk(clk), .rst(rst), .issue_i(ss_issue), .map_eq_i(ss_eq), .map_en_i(ss_en),
        .start_o(ss_start), .started_o(ss_started), .cycle_cnt_o(ss_cnt), .iend_o(ss_iend),
        .ended_o(ss_ended), .end2_o(ss_end2), .ended2_o(ss_ended2), .compare_o(ss_compare),
        .fail_o(ss_fail),
`ifdef ILA_MON_FAIL_LOG_EN
        .fail_vec_o(ss_fvec), .fail_cyc_o(ss_fcyc),
`endif
        .instr_cnt_o(ss_instr)
    );

    ila_instr_window_monitor #(.MULTI_SHOT(1)) dut_ms (
        .clk(clk), .rst(rst), .issue_i(ms_issue), .map_eq_i(ms_eq), .map_en_i(ms_en),
        .start_o(ms_start), .started_o(ms_started), .cycle_cnt_o(ms_cnt), .iend_o(ms_iend),
        .ended_o(ms_ended), .end2_o(ms_end2), .ended2_o(ms_ended2), .compare_o(ms_compare),
        .fail_o(ms_fail),
`ifdef ILA_MON_FAIL_LOG_EN
        .fail_vec_o(ms_fvec), .fail_cyc_o(ms_fcyc),
`endif
        .instr_cnt_o(ms_instr)
    );

    typedef struct {
        logic        issue;
        logic [12:0] eq;
        logic [12:0] en;
        logic        start;
        logic        started;
        logic [3:0]  cnt;
        logic        iend;
        logic        ended;
        logic        end2;
        logic        ended2;
        logic        compare;
        logic        fail;
    } vec_t;

    vec_t tbl[10];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic issue, input logic [12:0] eq, input logic [12:0] en,
                                input logic st, input logic sd, input logic [3:0] cnt,
                                input logic ie, input logic ed, input logic e2, input logic ed2,
                                input logic cmp, input logic fl);
        vec_t v;
        v.issue = issue; v.eq = eq; v.en = en;
        v.start = st; v.started = sd; v.cnt = cnt; v.iend = ie; v.ended = ed;
        v.end2 = e2; v.ended2 = ed2; v.compare = cmp; v.fail = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        // Single-shot trace: issue @0, pulses ignored later, masked/uncompared mismatches.
        tbl[0] = mk(1'b1, ALL, ALL, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, NO5, ALL, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(1'b1, NO3, NO3, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[3] = mk(1'b0, NO5, ALL, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[4] = mk(1'b1, ALL, ALL, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[5] = mk(1'b0, ALL, ALL, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tbl[6] = mk(1'b1, ALL, ALL, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tbl[7] = mk(1'b0, ALL, ALL, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tbl[8] = mk(1'b0, ALL, ALL, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tbl[9] = mk(1'b0, ALL, ALL, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss_started", {31'd0, ss_started}, 32'd0);
        check("rst_ss_cnt", {28'd0, ss_cnt}, 32'd0);
        check("rst_ss_fail", {31'd0, ss_fail}, 32'd0);
        check("rst_ms_instr", {24'd0, ms_instr}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ss_issue = tbl[i].issue;
            ss_eq    = tbl[i].eq;
            ss_en    = tbl[i].en;
            sb_q.push_back(tbl[i]);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check($sformatf("sb_empty_%0d", i), 32'd0, 32'd1);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                check($sformatf("c%0d_start", i),   {31'd0, ss_start},   {31'd0, e.start});
                check($sformatf("c%0d_started", i), {31'd0, ss_started}, {31'd0, e.started});
                check($sformatf("c%0d_cnt", i),     {28'd0, ss_cnt},     {28'd0, e.cnt});
                check($sformatf("c%0d_iend", i),    {31'd0, ss_iend},    {31'd0, e.iend});
                check($sformatf("c%0d_ended", i),   {31'd0, ss_ended},   {31'd0, e.ended});
                check($sformatf("c%0d_end2", i),    {31'd0, ss_end2},    {31'd0, e.end2});
                check($sformatf("c%0d_ended2", i),  {31'd0, ss_ended2},  {31'd0, e.ended2});
                check($sformatf("c%0d_compare", i), {31'd0, ss_compare}, {31'd0, e.compare});
                check($sformatf("c%0d_fail", i),    {31'd0, ss_fail},    {31'd0, e.fail});
            end
        end
        ss_issue = 1'b0;
`ifdef ILA_MON_FAIL_LOG_EN
        check("log_vec", {19'd0, ss_fvec}, 32'h020);
        check("log_cyc", {28'd0, ss_fcyc}, 32'd2);
`endif

        // Multi-shot: issue held high, starts every 5 cycles, fail sticky across instructions.
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int p;
            @(posedge clk); #1;
            ms_issue = 1'b1;
            ms_eq    = (k == 8) ? NO5 : ALL;
            ms_en    = ALL;
            @(negedge clk);
            p = (k >= 1) ? ((k - 1) % 5) : 4;
            check($sformatf("ms%0d_start", k), {31'd0, ms_start}, (p == 0) ? 32'd1 : 32'd0);
            check($sformatf("ms%0d_cnt", k), {28'd0, ms_cnt}, (p == 4) ? 32'd0 : p);
            check($sformatf("ms%0d_end2", k), {31'd0, ms_end2}, (p == 3) ? 32'd1 : 32'd0);
            check($sformatf("ms%0d_instr", k), {24'd0, ms_instr}, k / 5);
            check($sformatf("ms%0d_fail", k), {31'd0, ms_fail}, (k >= 9) ? 32'd1 : 32'd0);
            check($sformatf("ms%0d_ended2", k), {31'd0, ms_ended2}, 32'd0);
        end
        ms_issue = 1'b0;

        // Async reset in ENDED at cnt=2 with fail already set, then a fresh issue.
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 ss_issue = 1'b1; ss_eq = ALL; ss_en = ALL;
        @(posedge clk); #1 ss_issue = 1'b0;
        @(posedge clk); #1 ss_eq = NO5;
        @(posedge clk); #1 ss_eq = ALL;
        @(negedge clk);
        check("pre_rst_cnt", {28'd0, ss_cnt}, 32'd2);
        check("pre_rst_fail", {31'd0, ss_fail}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_started", {31'd0, ss_started}, 32'd0);
        check("arst_cnt", {28'd0, ss_cnt}, 32'd0);
        check("arst_ended", {31'd0, ss_ended}, 32'd0);
        check("arst_compare", {31'd0, ss_compare}, 32'd0);
        check("arst_fail", {31'd0, ss_fail}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 ss_issue = 1'b1;
        @(negedge clk);
        check("reissue_nostart", {31'd0, ss_start}, 32'd0);
        @(posedge clk); #1 ss_issue = 1'b0;
        @(negedge clk);
        check("reissue_start", {31'd0, ss_start}, 32'd1);
        check("reissue_cnt", {28'd0, ss_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
